// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the fifo_flex family.
// Pointer/count widths are derived here so the top and the storage
// array agree on address width without repeating the arithmetic.
package fifo_pkg;

    localparam int FIFO_MAX_DEPTH = 1024;
    localparam int FIFO_MAX_WIDTH = 1024;

    // Smallest r such that 2**r >= value (value >= 1).
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Bits needed to address one storage word.
    function automatic int addr_width(input int depth);
        return log2_ceil(depth);
    endfunction

    // Pointer / level width: one extra bit so full and empty differ.
    function automatic int count_width(input int depth);
        return log2_ceil(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// Storage for fifo_flex: simple dual-port register array with one
// synchronous write port and one asynchronous (combinational) read port.
// Contents are intentionally not reset.
module fifo_flex_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    // Write port: store the incoming word at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Read port is combinational so the head word falls through.
    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: single-clock first-word-fall-through FIFO.
// Optional feature macro FIFO_FLEX_LEVEL_EN adds registered levelOut,
// almostFullOut and almostEmptyOut; without it those ports and their
// logic are absent and full/empty behaviour is unchanged.
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  flushIn,
    input  logic [DATA_WIDTH-1:0] wrDataIn,
    input  logic                  wrValidIn,
    output logic                  wrReadyOut,
    output logic [DATA_WIDTH-1:0] rdDataOut,
    output logic                  rdValidOut,
    input  logic                  rdReadyIn
`ifdef FIFO_FLEX_LEVEL_EN
    ,
    output logic [count_width(FIFO_DEPTH)-1:0] levelOut,
    output logic                  almostFullOut,
    output logic                  almostEmptyOut
`endif
);

    localparam int AW = addr_width(FIFO_DEPTH);
    localparam int CW = count_width(FIFO_DEPTH);
    localparam logic [CW-1:0] PTR_ONE = CW'(1);

    // Reject parameter sets the pointer arithmetic cannot support.
    if (DATA_WIDTH < 1 || DATA_WIDTH > FIFO_MAX_WIDTH ||
        FIFO_DEPTH < 2 || FIFO_DEPTH > FIFO_MAX_DEPTH ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        AFULL_THRESH < 0 || AFULL_THRESH > FIFO_DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH) begin : g_bad_params
        $error("fifo_flex: illegal parameter combination");
    end

    logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
    logic          full, empty;
    logic          wr_en, rd_en;

    // Same low bits with opposite wrap bit means the writer is a lap ahead.
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // Handshakes qualified by registered flags; flush suppresses both.
    assign wr_en = wrValidIn && !full  && !flushIn;
    assign rd_en = rdReadyIn && !empty && !flushIn;

    // Flags depend only on the pointer registers, never on inputs.
    assign wrReadyOut = !full;
    assign rdValidOut = !empty;

    // Next pointer values; flush returns both pointers to zero.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flushIn) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Pointer registers, cleared asynchronously by reset.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    fifo_flex_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (clkIn),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (wrDataIn),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (rdDataOut)
    );

`ifdef FIFO_FLEX_LEVEL_EN
    localparam logic [CW-1:0] AFULL_LVL  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_LVL = CW'(AEMPTY_THRESH);

    logic [CW-1:0] level_reg, level_next;
    logic          afull_reg, aempty_reg;

    // Level tracks write-only / pop-only; simultaneous ops cancel.
    always_comb begin
        level_next = level_reg;
        if (flushIn) begin
            level_next = '0;
        end else if (wr_en && !rd_en) begin
            level_next = level_reg + PTR_ONE;
        end else if (rd_en && !wr_en) begin
            level_next = level_reg - PTR_ONE;
        end
    end

    // Thresholds are evaluated on the next level so flags line up with it.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            level_reg  <= '0;
            afull_reg  <= 1'b0;
            aempty_reg <= 1'b1;
        end else begin
            level_reg  <= level_next;
            afull_reg  <= (level_next >= AFULL_LVL);
            aempty_reg <= (level_next <= AEMPTY_LVL);
        end
    end

    assign levelOut       = level_reg;
    assign almostFullOut  = afull_reg;
    assign almostEmptyOut = aempty_reg;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex: directed scenarios plus a random
// soak, checked by a queue-based reference model and a negedge monitor.
// Level/almost-flag checks are active when FIFO_FLEX_LEVEL_EN is defined.
module tb_fifo_flex;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          clkIn = 1'b0;
    logic          rstIn;
    logic          flushIn;
    logic [DW-1:0] wrDataIn;
    logic          wrValidIn;
    logic          wrReadyOut;
    logic [DW-1:0] rdDataOut;
    logic          rdValidOut;
    logic          rdReadyIn;
`ifdef FIFO_FLEX_LEVEL_EN
    logic [4:0]    levelOut;
    logic          almostFullOut;
    logic          almostEmptyOut;
`endif

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    fifo_flex #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .clkIn      (clkIn),
        .rstIn      (rstIn),
        .flushIn    (flushIn),
        .wrDataIn   (wrDataIn),
        .wrValidIn  (wrValidIn),
        .wrReadyOut (wrReadyOut),
        .rdDataOut  (rdDataOut),
        .rdValidOut (rdValidOut),
        .rdReadyIn  (rdReadyIn)
`ifdef FIFO_FLEX_LEVEL_EN
        ,
        .levelOut       (levelOut),
        .almostFullOut  (almostFullOut),
        .almostEmptyOut (almostEmptyOut)
`endif
    );

    always #5 clkIn = ~clkIn;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic idle();
        wrValidIn = 1'b0;
        rdReadyIn = 1'b0;
        flushIn   = 1'b0;
    endtask

    task automatic fill(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            wrValidIn = 1'b1;
            wrDataIn  = $urandom;
            rdReadyIn = 1'b0;
            tick();
        end
        wrValidIn = 1'b0;
    endtask

    task automatic drain();
        wrValidIn = 1'b0;
        rdReadyIn = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            tick();
        end
        rdReadyIn = 1'b0;
    endtask

    // Reference model + monitor: flags from model occupancy, head word
    // from the front of the expected queue, then apply the edge's effect.
    always @(negedge clkIn) begin
        int n;
        if (rstIn) begin
            n = exp_q.size();
            chk("wr_ready", 64'(wrReadyOut), 64'(n != DEPTH));
            chk("rd_valid", 64'(rdValidOut), 64'(n != 0));
`ifdef FIFO_FLEX_LEVEL_EN
            chk("level", 64'(levelOut), 64'(n));
            chk("afull", 64'(almostFullOut), 64'(n >= AF));
            chk("aempty", 64'(almostEmptyOut), 64'(n <= AE));
`endif
            if (n != 0) begin
                chk("head_data", 64'(rdDataOut), 64'(exp_q[0]));
            end
            if (flushIn) begin
                exp_q.delete();
            end else begin
                if (rdReadyIn && n != 0) begin
                    void'(exp_q.pop_front());
                end
                if (wrValidIn && n != DEPTH) begin
                    exp_q.push_back(wrDataIn);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wp;
        int rp;
        rstIn    = 1'b0;
        wrDataIn = '0;
        idle();

        // Power-up reset state.
        #1;
        chk("reset_wr_ready", 64'(wrReadyOut), 64'd1);
        chk("reset_rd_valid", 64'(rdValidOut), 64'd0);
`ifdef FIFO_FLEX_LEVEL_EN
        chk("reset_level", 64'(levelOut), 64'd0);
        chk("reset_aempty", 64'(almostEmptyOut), 64'd1);
        chk("reset_afull", 64'(almostFullOut), 64'd0);
`endif
        tick();
        tick();
        rstIn = 1'b1;

        // Latency: word written at edge N is visible only after edge N.
        wrValidIn = 1'b1;
        wrDataIn  = 32'h1234;
        chk("lat_before", 64'(rdValidOut), 64'd0);
        tick();
        wrValidIn = 1'b0;
        chk("lat_valid", 64'(rdValidOut), 64'd1);
        chk("lat_data", 64'(rdDataOut), 64'h1234);
        drain();

        // Ordering: fill 0x00..0x0F, watch almost-full and full, then drain.
        for (int i = 0; i < DEPTH; i++) begin
            wrValidIn = 1'b1;
            wrDataIn  = DW'(i);
            tick();
            chk("fill_wr_ready", 64'(wrReadyOut), 64'((i + 1) != DEPTH));
`ifdef FIFO_FLEX_LEVEL_EN
            chk("fill_afull", 64'(almostFullOut), 64'((i + 1) >= 14));
`endif
        end
        wrValidIn = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rdReadyIn = 1'b1;
            chk("order_data", 64'(rdDataOut), 64'(i));
            tick();
        end
        rdReadyIn = 1'b0;
        chk("order_empty", 64'(rdValidOut), 64'd0);

        // Full with simultaneous pop: write rejected, slot free next cycle.
        fill(DEPTH);
        wrValidIn = 1'b1;
        wrDataIn  = 32'hAA;
        rdReadyIn = 1'b1;
        tick();
        rdReadyIn = 1'b0;
        chk("fullpop_wr_ready", 64'(wrReadyOut), 64'd1);
`ifdef FIFO_FLEX_LEVEL_EN
        chk("fullpop_level", 64'(levelOut), 64'd15);
`endif
        tick();
        wrValidIn = 1'b0;
        chk("fullpop_refull", 64'(wrReadyOut), 64'd0);
`ifdef FIFO_FLEX_LEVEL_EN
        chk("fullpop_level16", 64'(levelOut), 64'd16);
`endif
        drain();

        // Streaming at level 1 for 40 cycles; pointers wrap.
        fill(1);
        for (int i = 0; i < 40; i++) begin
            wrValidIn = 1'b1;
            wrDataIn  = $urandom;
            rdReadyIn = 1'b1;
            tick();
            chk("stream_valid", 64'(rdValidOut), 64'd1);
`ifdef FIFO_FLEX_LEVEL_EN
            chk("stream_level", 64'(levelOut), 64'd1);
`endif
        end
        drain();

        // Flush at level 9 overrides a concurrent write and pop.
        fill(9);
        flushIn   = 1'b1;
        wrValidIn = 1'b1;
        wrDataIn  = 32'h55;
        rdReadyIn = 1'b1;
        tick();
        idle();
        chk("flush_rd_valid", 64'(rdValidOut), 64'd0);
        chk("flush_wr_ready", 64'(wrReadyOut), 64'd1);
`ifdef FIFO_FLEX_LEVEL_EN
        chk("flush_level", 64'(levelOut), 64'd0);
`endif
        wrValidIn = 1'b1;
        wrDataIn  = 32'h77;
        tick();
        wrValidIn = 1'b0;
        chk("flush_next_data", 64'(rdDataOut), 64'h77);
        drain();

        // Asynchronous reset mid-stream with 5 words stored.
        fill(5);
        rstIn = 1'b0;
        #1;
        chk("arst_wr_ready", 64'(wrReadyOut), 64'd1);
        chk("arst_rd_valid", 64'(rdValidOut), 64'd0);
`ifdef FIFO_FLEX_LEVEL_EN
        chk("arst_level", 64'(levelOut), 64'd0);
        chk("arst_afull", 64'(almostFullOut), 64'd0);
        chk("arst_aempty", 64'(almostEmptyOut), 64'd1);
`endif
        exp_q.delete();
        tick();
        rstIn = 1'b1;

        // Random soak in phases of differing write/read pressure.
        for (int p = 0; p < 15; p++) begin
            wp = int'($urandom_range(90, 10));
            rp = int'($urandom_range(90, 10));
            for (int c = 0; c < 200; c++) begin
                wrValidIn = (int'($urandom_range(99, 0)) < wp);
                wrDataIn  = $urandom;
                rdReadyIn = (int'($urandom_range(99, 0)) < rp);
                flushIn   = ($urandom_range(199, 0) == 0);
                tick();
            end
        end
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits, range 1..1024.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: storage words; power of two, range 2..1024.
REQ-003 SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-2: almostFullOut asserts when level >= this value.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2: almostEmptyOut asserts when level <= this value.
REQ-005 SHALL have port clkIn, input, 1 bit: single clock; all logic rising-edge.
REQ-006 SHALL have port rstIn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port flushIn, input, 1 bit: synchronous discard of all contents.
REQ-008 SHALL have port wrDataIn, input, DATA_WIDTH bits: write data.
REQ-009 SHALL have port wrValidIn, input, 1 bit: write request.
REQ-010 SHALL have port wrReadyOut, output, 1 bit: space available.
REQ-011 SHALL have port rdDataOut, output, DATA_WIDTH bits: head word, first-word-fall-through.
REQ-012 SHALL have port rdValidOut, output, 1 bit: rdDataOut holds a valid word.
REQ-013 SHALL have port rdReadyIn, input, 1 bit: consumer accepts head word.
REQ-014 SHALL have port levelOut, output, $clog2(FIFO_DEPTH)+1 bits: stored word count (present only with FIFO_FLEX_LEVEL_EN).
REQ-015 SHALL have ports almostFullOut and almostEmptyOut, output, 1 bit each (present only with FIFO_FLEX_LEVEL_EN).

Function
REQ-016 SHALL accept a write when wrValidIn && wrReadyOut, and pop when rdValidOut && rdReadyIn, both sampled on the same clkIn edge.
REQ-017 SHALL drive wrReadyOut = (level != FIFO_DEPTH) and rdValidOut = (level != 0), both from registered state only; no combinational path from any input to them.
REQ-018 SHALL deliver a word written at edge N to rdDataOut with rdValidOut=1 after edge N when the FIFO was empty (latency 1; no same-cycle bypass).
REQ-019 SHALL preserve strict write order; pointers are $clog2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; the MSB distinguishes full from empty.
REQ-020 SHALL update level by +1 on write-only, -1 on pop-only, and leave it unchanged on simultaneous write and pop.
REQ-021 SHALL, when full, ignore wrValidIn and leave contents and wrDataIn-visible state unchanged, even if a pop occurs in the same cycle; the freed slot is writable next cycle.
REQ-022 SHALL, when empty, ignore rdReadyIn; rdDataOut value is don't-care while rdValidOut=0.
REQ-023 SHALL, on flushIn=1 at an edge, set level to 0 and both pointers to 0, overriding any write or pop in that cycle.
REQ-024 SHALL hold rdDataOut stable while rdValidOut=1 and rdReadyIn=0.

Reset
REQ-025 SHALL, on rstIn low, asynchronously clear pointers and level: wrReadyOut=1, rdValidOut=0, levelOut=0, almostFullOut=0, almostEmptyOut=1.
REQ-026 SHALL not reset storage contents; reset release is used synchronously so the first write is taken on the first edge with rstIn high.

Configuration
REQ-027 SHALL, with macro FIFO_FLEX_LEVEL_EN defined, provide levelOut, almostFullOut, almostEmptyOut as registered outputs valid the same cycle as the level they reflect.
REQ-028 SHALL, without FIFO_FLEX_LEVEL_EN, omit those ports and their logic; full/empty behaviour is otherwise identical.

Structure
REQ-029 SHALL place address-width and count-width constants and the log2 helper function in shared package fifo_pkg.
REQ-030 SHALL instantiate one sub-module fifo_flex_mem: simple dual-port register array, one synchronous write port, one asynchronous read port.

Verification
REQ-031 SHALL test reset: after rstIn low mid-stream with 5 words stored -> wrReadyOut=1, rdValidOut=0, levelOut=0 immediately, before any edge.
REQ-032 SHALL test ordering: write 0x00..0x0F into DEPTH=16 with rdReadyIn=0 -> wrReadyOut=0 after 16th edge, almostFullOut=1 from level 14; drain -> 0x00..0x0F in order.
REQ-033 SHALL test full with simultaneous pop: full, wrValidIn=1 with 0xAA, rdReadyIn=1 -> one pop, 0xAA not stored, level=15; next cycle 0xAA accepted, level=16.
REQ-034 SHALL test streaming: level=1, write and pop every cycle for 40 cycles -> level stays 1, pointers wrap twice, no data loss.
REQ-035 SHALL test flush: level=9, flushIn=1 with wrValidIn=1 -> level=0, rdValidOut=0 next cycle, written word discarded.
REQ-036 SHALL test latency: empty, single write 0x1234 at edge N -> rdValidOut=1, rdDataOut=0x1234 after edge N, not before.
